pipe_stage_buf: RTL and testbench

- Parametrised elastic pipeline-stage register that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries an opaque WIDTH-bit payload, with a valid/ready handshake on each side and a 2-entry skid buffer, so upstream ready is driven from a flop and never depends combinationally on downstream ready.
- A synchronous flush squashes both entries to a bubble. The bubble is a NOP payload, equivalent to the old RTYPE/zero reset image.

---
 rtl/pipe_pkg.sv | 53 +++++
 rtl/pipe_stage_buf_sat_counter.sv | 27 ++
 rtl/pipe_stage_buf.sv | 139 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the elastic pipeline-stage buffers.
//   pstate_t   occupancy state of one pipe_stage_buf (empty / main / main+skid)
//   *_t        per-stage payload structs; $bits() of these sets WIDTH
//   *_BUBBLE   NOP payload images used as the BUBBLE parameter of each stage
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pstate_t;

    typedef enum logic [6:0] {
        RTYPE  = 7'b0110011,
        ITYPE  = 7'b0010011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        BRANCH = 7'b1100011
    } opcode_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
    } idex_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rd;
        logic [31:0] alu_out;
        logic [31:0] store_val;
    } exmem_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rd;
        logic [31:0] wb_val;
    } memwb_t;

    // An all-zero RTYPE writing x0 has no architectural effect, so it is the NOP image.
    localparam ifid_t  IFID_BUBBLE  = '{pc: '0, instr: '0};
    localparam idex_t  IDEX_BUBBLE  = '{opcode: RTYPE, rd: '0, rs1_val: '0, rs2_val: '0, imm: '0};
    localparam exmem_t EXMEM_BUBBLE = '{opcode: RTYPE, rd: '0, alu_out: '0, store_val: '0};
    localparam memwb_t MEMWB_BUBBLE = '{opcode: RTYPE, rd: '0, wb_val: '0};

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// pipe_sat_counter: CNT_W-bit saturating event counter.
//   CLK   in   clock, rising edge
//   nRST  in   asynchronous reset, active-low (only way to clear)
//   inc   in   count one event this cycle
//   cnt   out  current count, sticks at all-ones
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic elastic pipeline-stage register with a 2-entry skid
// buffer. in_ready comes straight from the state flop, so it never depends
// combinationally on out_ready.
//   CLK, nRST                   clock (rising) / asynchronous active-low reset
//   flush                       synchronous squash of both entries to BUBBLE
//   in_valid/in_ready/in_data   upstream handshake and WIDTH-bit payload
//   out_valid/out_ready/out_data downstream handshake and head payload
//   stall_cnt/flush_cnt/xfer_cnt CNT_W-bit performance counters
// Optional build macro PIPE_STAGE_PERF_EN enables the saturating counters;
// without it the counter ports read 0 and no counter flops exist.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] xfer_cnt
);

    pstate_t          r_state;
    pstate_t          w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_acc;
    logic             w_take;

    assign in_ready  = (r_state != PS_TWO);
    assign out_valid = (r_state != PS_EMPTY);
    assign out_data  = r_main;

    assign w_acc  = in_valid && in_ready;
    assign w_take = out_valid && out_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= PS_EMPTY;
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            // Flush wins over any accept; the offered payload is dropped.
            w_state_nxt = PS_EMPTY;
            w_main_nxt  = BUBBLE;
            w_skid_nxt  = BUBBLE;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = PS_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                PS_ONE: begin
                    if (w_acc && !w_take) begin
                        w_state_nxt = PS_TWO;
                        w_skid_nxt  = in_data;
                    end else if (w_acc && w_take) begin
                        w_main_nxt  = in_data;
                    end else if (w_take) begin
                        w_state_nxt = PS_EMPTY;
                        w_main_nxt  = BUBBLE;
                    end
                end
                PS_TWO: begin
                    // in_ready is low here, so only the drain path exists.
                    if (w_take) begin
                        w_state_nxt = PS_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE;
                    end
                end
                default: begin
                    w_state_nxt = PS_EMPTY;
                    w_main_nxt  = BUBBLE;
                    w_skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic w_inc_stall;
    logic w_inc_flush;

    assign w_inc_stall = out_valid && !out_ready;
    assign w_inc_flush = flush && (r_state != PS_EMPTY);

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (w_inc_stall),
        .cnt  (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (w_inc_flush),
        .cnt  (flush_cnt)
    );

    // A take in a flush cycle still completed downstream, so it counts.
    pipe_sat_counter #(.CNT_W(CNT_W)) u_xfer_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (w_take),
        .cnt  (xfer_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign xfer_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed bench for pipe_stage_buf (WIDTH=8, BUBBLE=8'hA5,
// CNT_W=4). Counter expectations follow PIPE_STAGE_PERF_EN: real counts when
// defined, zero when not.
module tb_pipe_stage_buf;

    localparam int         WIDTH  = 8;
    localparam logic [7:0] BUBBLE = 8'hA5;
    localparam int         CNT_W  = 4;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             nRST;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] xfer_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_buf #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [CNT_W-1:0] cexp(input int n);
        return PERF ? CNT_W'(n) : '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return on the falling edge where outputs are sampled
    // and the next inputs are driven.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_cnts(input string tag, input int s, input int f, input int x);
        check({tag, "_stall"}, 32'(stall_cnt), 32'(cexp(s)));
        check({tag, "_flush"}, 32'(flush_cnt), 32'(cexp(f)));
        check({tag, "_xfer"},  32'(xfer_cnt),  32'(cexp(x)));
    endtask

    initial begin
        logic [7:0] v;
        nRST      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        // Reset image
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'hA5);
        check_cnts("rst", 0, 0, 0);
        nRST = 1'b1;
        step();

        // Streaming 01..05 with out_ready high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = 8'(i);
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data",  32'(out_data),  32'(i));
            check("stream_ready", 32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", 32'(out_valid), 32'd0);
        check("stream_drain_data",  32'(out_data),  32'hA5);
        check_cnts("stream", 0, 0, 5);

        // Stall: 10, 11 accepted, 12 held off
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h10;
        step();
        check("stall_one_data",  32'(out_data), 32'h10);
        check("stall_one_ready", 32'(in_ready), 32'd1);
        in_data = 8'h11;
        step();
        check("stall_two_ready", 32'(in_ready), 32'd0);
        check("stall_two_data",  32'(out_data), 32'h10);
        in_data = 8'h12;
        step();
        check("stall_hold_ready", 32'(in_ready), 32'd0);
        check("stall_hold_data",  32'(out_data), 32'h10);
        check_cnts("stall_hold", 2, 0, 5);
        out_ready = 1'b1;
        step();
        check("drain_11", 32'(out_data), 32'h11);
        check("drain_ready", 32'(in_ready), 32'd1);
        step();
        check("drain_12", 32'(out_data), 32'h12);
        check("drain_12_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        check("drain_empty", 32'(out_valid), 32'd0);
        check_cnts("drain", 2, 0, 8);

        // Flush in PS_TWO with 20 offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h30;
        step();
        in_data = 8'h31;
        step();
        check("pre_flush_ready", 32'(in_ready), 32'd0);
        flush   = 1'b1;
        in_data = 8'h20;
        step();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_data",  32'(out_data),  32'hA5);
        check("flush_ready", 32'(in_ready),  32'd1);
        check_cnts("flush", 4, 1, 8);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush_drop_valid", 32'(out_valid), 32'd0);
        check("flush_drop_data",  32'(out_data),  32'hA5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_empty_cnt", 32'(flush_cnt), 32'(cexp(1)));

        // Saturation: one entry held for 20 stalled cycles
        in_valid = 1'b1;
        in_data  = 8'h40;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("sat_stall", 32'(stall_cnt), 32'(cexp(15)));
        check("sat_data",  32'(out_data),  32'h40);
        check("sat_valid", 32'(out_valid), 32'd1);

        // Asynchronous reset mid-stream in PS_TWO
        in_valid = 1'b1;
        in_data  = 8'h50;
        step();
        check("pre_arst_ready", 32'(in_ready), 32'd0);
        #2;
        nRST = 1'b0;
        #1;
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data",  32'(out_data),  32'hA5);
        check_cnts("arst", 0, 0, 0);
        in_valid = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;

        // Clean restart after reset
        in_valid  = 1'b1;
        out_ready = 1'b1;
        v         = 8'h60;
        in_data   = v;
        step();
        in_valid = 1'b0;
        check("restart_data",  32'(out_data),  32'(v));
        check("restart_valid", 32'(out_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
